damage_sequencer: RTL and testbench

- Turn-level controller for the damage datapath (damage register, damage calculator, HP register, bar-decrement counter, white-bar drawer).
- Accepts one attack request per turn and pulses/holds the datapath enables in order.
- Steps the HP bar down one column at a time, with one white draw per step.
- Reports turn completion and a sticky battle-over flag to the top-level game FSM.

---
 rtl/damage_sequencer.sv | 155 +++++++++++++++
 tb/tb_damage_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/damage_sequencer.sv
// Turn-level controller for the damage datapath: load, calculate, commit, then step the HP bar down with one white draw per column.
// Optional DMG_SEQ_TIMEOUT_EN adds a per-column draw timeout with a sticky timeout_err flag.
module damage_sequencer #(
    parameter int MOVE_W       = 3,
    parameter int DRAW_TIMEOUT = 1023,
    parameter int TO_W         = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [MOVE_W-1:0] move_in,
    input  logic              move_valid,
    output logic              move_ready,
    output logic [MOVE_W-1:0] move_out,
    output logic              enable_DMG_reg,
    output logic              enable_DMG_calc,
    output logic              enable_HP_calc,
    output logic              enable_decrement_control,
    output logic              enable_draw_decrease,
    input  logic              done_damage,
    input  logic              done_decrement,
    input  logic              game_over,
    output logic              turn_done,
    output logic              battle_over,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_COMMIT,
        S_CHECK,
        S_STEP,
        S_SETTLE,
        S_DRAW,
        S_FINISH,
        S_OVER
    } state_t;

    state_t state;

    if (DRAW_TIMEOUT < 1 || DRAW_TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout_cfg
        $error("damage_sequencer: DRAW_TIMEOUT does not fit in TO_W bits");
    end

`ifdef DMG_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] draw_cnt;
`endif

    // Every output is decided together with the next state, so each one
    // reflects the state the machine has just entered (Moore, registered).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                    <= S_IDLE;
            move_ready               <= 1'b0;
            move_out                 <= '0;
            enable_DMG_reg           <= 1'b0;
            enable_DMG_calc          <= 1'b0;
            enable_HP_calc           <= 1'b0;
            enable_decrement_control <= 1'b0;
            enable_draw_decrease     <= 1'b0;
            turn_done                <= 1'b0;
            battle_over              <= 1'b0;
            busy                     <= 1'b0;
            timeout_err              <= 1'b0;
`ifdef DMG_SEQ_TIMEOUT_EN
            draw_cnt                 <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout; the single-cycle
            // pulses default low here and are re-asserted by the case below.
            enable_DMG_reg           <= 1'b0;
            enable_DMG_calc          <= 1'b0;
            enable_HP_calc           <= 1'b0;
            enable_decrement_control <= 1'b0;
            turn_done                <= 1'b0;

            case (state)
                S_IDLE: begin
                    move_ready <= 1'b1;
                    if (move_ready && move_valid && $onehot(move_in)) begin
                        state          <= S_LOAD;
                        move_out       <= move_in;
                        move_ready     <= 1'b0;
                        busy           <= 1'b1;
                        enable_DMG_reg <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state           <= S_CALC;
                    enable_DMG_calc <= 1'b1;
                end
                S_CALC: begin
                    state          <= S_COMMIT;
                    enable_HP_calc <= 1'b1;
                end
                S_COMMIT: state <= S_CHECK;
                S_CHECK: begin
                    // The bar is animated to zero even when the battle ends.
                    if (game_over) battle_over <= 1'b1;
                    state                    <= S_STEP;
                    enable_decrement_control <= 1'b1;
                end
                S_STEP: state <= S_SETTLE;
                S_SETTLE: begin
                    if (done_decrement) begin
                        state     <= S_FINISH;
                        turn_done <= 1'b1;
                    end else begin
                        state                <= S_DRAW;
                        enable_draw_decrease <= 1'b1;
`ifdef DMG_SEQ_TIMEOUT_EN
                        draw_cnt             <= '0;
`endif
                    end
                end
                S_DRAW: begin
                    if (done_damage) begin
                        state                    <= S_STEP;
                        enable_draw_decrease     <= 1'b0;
                        enable_decrement_control <= 1'b1;
                    end
`ifdef DMG_SEQ_TIMEOUT_EN
                    else if (draw_cnt == TO_W'(DRAW_TIMEOUT - 1)) begin
                        state                <= S_FINISH;
                        enable_draw_decrease <= 1'b0;
                        timeout_err          <= 1'b1;
                        turn_done            <= 1'b1;
                    end else begin
                        draw_cnt <= draw_cnt + 1'b1;
                    end
`endif
                end
                S_FINISH: begin
                    move_out <= '0;
                    busy     <= 1'b0;
                    if (battle_over) begin
                        state <= S_OVER;
                    end else begin
                        state      <= S_IDLE;
                        move_ready <= 1'b1;
                    end
                end
                S_OVER: state <= S_OVER;
                default: begin
                    state      <= S_IDLE;
                    move_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_damage_sequencer.sv
// Self-checking bench for damage_sequencer: randomized turns against a turn-level reference model
// (steps = columns, draws = columns-1, fixed draw length), plus reset, illegal-code, game-over and timeout cases.
module tb_damage_sequencer;

    localparam int MOVE_W = 3;
`ifdef DMG_SEQ_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`else
    localparam int TIMEOUT = 1023;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [MOVE_W-1:0] move_in;
    logic              move_valid;
    logic              move_ready;
    logic [MOVE_W-1:0] move_out;
    logic              enable_DMG_reg;
    logic              enable_DMG_calc;
    logic              enable_HP_calc;
    logic              enable_decrement_control;
    logic              enable_draw_decrease;
    logic              done_damage;
    logic              done_decrement;
    logic              game_over;
    logic              turn_done;
    logic              battle_over;
    logic              busy;
    logic              timeout_err;

    damage_sequencer #(
        .MOVE_W      (MOVE_W),
        .DRAW_TIMEOUT(TIMEOUT),
        .TO_W        (10)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .move_in                 (move_in),
        .move_valid              (move_valid),
        .move_ready              (move_ready),
        .move_out                (move_out),
        .enable_DMG_reg          (enable_DMG_reg),
        .enable_DMG_calc         (enable_DMG_calc),
        .enable_HP_calc          (enable_HP_calc),
        .enable_decrement_control(enable_decrement_control),
        .enable_draw_decrease    (enable_draw_decrease),
        .done_damage             (done_damage),
        .done_decrement          (done_decrement),
        .game_over               (game_over),
        .turn_done               (turn_done),
        .battle_over             (battle_over),
        .busy                    (busy),
        .timeout_err             (timeout_err)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Turn observation and datapath model state
    int   cyc, steps, draw_run, n_reg, n_calc, n_hp, n_done;
    int   reg_cyc, calc_cyc, hp_cyc, first_dec, viol;
    int   n_cols, d_len;
    bit   go_all, in_turn, prev_dec;
    logic [MOVE_W-1:0] cur_move;
    int   bursts[$];

    task automatic clear_model();
        cyc = 0; steps = 0; draw_run = 0; n_reg = 0; n_calc = 0; n_hp = 0; n_done = 0;
        reg_cyc = 0; calc_cyc = 0; hp_cyc = 0; first_dec = 0; viol = 0;
        prev_dec = 1'b0;
        bursts.delete();
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({move_ready, move_out, enable_DMG_reg, enable_DMG_calc, enable_HP_calc,
                    enable_decrement_control, enable_draw_decrease, turn_done, battle_over,
                    busy, timeout_err});
    endfunction

    // One clock: observe outputs at the falling edge, then drive the datapath responses.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (enable_DMG_reg)  begin n_reg++;  reg_cyc  = cyc; end
        if (enable_DMG_calc) begin n_calc++; calc_cyc = cyc; end
        if (enable_HP_calc)  begin n_hp++;   hp_cyc   = cyc; end
        if (enable_decrement_control) begin
            steps++;
            if (first_dec == 0) first_dec = cyc;
        end
        if (enable_draw_decrease) draw_run++;
        else if (draw_run > 0) begin
            bursts.push_back(draw_run);
            draw_run = 0;
        end
        if (turn_done) n_done++;
        if (in_turn && (move_ready || !busy || move_out !== cur_move)) viol++;
        if (turn_done) in_turn = 1'b0;
        // Outside the states that listen to them, the done lines carry noise.
        done_damage    = enable_draw_decrease ? (d_len != 0 && draw_run >= d_len)
                                              : 1'($urandom_range(0, 1));
        done_decrement = prev_dec ? (steps >= n_cols) : 1'($urandom_range(0, 1));
        prev_dec       = enable_decrement_control;
        game_over      = go_all ? 1'b1 : ((cyc == 4) ? 1'b0 : 1'($urandom_range(0, 1)));
    endtask

    task automatic start_turn(input logic [MOVE_W-1:0] move, input int cols, input int dlen,
                              input bit go, input bit hold);
        check("ready_before_turn", move_ready, 1);
        clear_model();
        n_cols = cols; d_len = dlen; go_all = go;
        move_in = move; move_valid = 1'b1; cur_move = move; in_turn = 1'b1;
        tick();
        if (hold) move_in = (move == 3'b100) ? 3'b001 : (move << 1);
        else      move_valid = 1'b0;
    endtask

    task automatic finish_turn(input int exp_steps, input int exp_draws, input int exp_len,
                               input bit exp_bo, input bit exp_to);
        int budget = 0;
        int bad = 0;
        while (n_done == 0 && budget < 3000) begin
            tick();
            budget++;
        end
        move_valid = 1'b0;
        check("turn_done_seen", n_done, 1);
        check("dmg_reg_cycle", reg_cyc, 1);
        check("dmg_calc_cycle", calc_cyc, 2);
        check("hp_calc_cycle", hp_cyc, 3);
        check("first_step_cycle", first_dec, 5);
        check("load_pulses", n_reg + n_calc + n_hp, 3);
        check("step_pulses", steps, exp_steps);
        check("draw_bursts", bursts.size(), exp_draws);
        foreach (bursts[i]) if (bursts[i] != exp_len) bad++;
        check("draw_len_bad", bad, 0);
        check("turn_violations", viol, 0);
        go_all = 1'b0;
        tick();
        check("post_move_out", move_out, 0);
        check("post_ready", move_ready, !exp_bo);
        check("post_busy", busy, 0);
        check("post_turn_done", turn_done, 0);
        check("post_battle_over", battle_over, exp_bo);
        check("post_timeout_err", timeout_err, exp_to);
    endtask

    task automatic illegal(input logic [MOVE_W-1:0] code);
        clear_model();
        in_turn = 1'b0;
        move_in = code; move_valid = 1'b1;
        repeat (3) tick();
        move_valid = 1'b0;
        repeat (3) tick();
        check("illegal_activity", n_reg + n_calc + n_hp + steps + draw_run + n_done, 0);
        check("illegal_ready", move_ready, 1);
        check("illegal_move_out", move_out, 0);
        check("illegal_busy", busy, 0);
    endtask

    task automatic do_reset();
        in_turn = 1'b0; go_all = 1'b0; move_valid = 1'b0;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        clear_model();
    endtask

    initial begin
        int budget;
        reset = 1'b1; move_in = '0; move_valid = 1'b0;
        done_damage = 1'b0; done_decrement = 1'b0; game_over = 1'b0;
        n_cols = 1; d_len = 1; go_all = 1'b0; in_turn = 1'b0; cur_move = '0;
        clear_model();
        #2 reset = 1'b0;
        tick(); tick();
        check("reset_outputs", out_vec(), 0);
        reset = 1'b1;
        tick();
        check("ready_after_release", move_ready, 1);

        // Directed: quick attack, 10 columns, 3-cycle draws
        start_turn(3'b001, 10, 3, 1'b0, 1'b0);
        finish_turn(10, 9, 3, 1'b0, 1'b0);

        // Zero-column damage: no DRAW at all
        start_turn(3'b010, 1, 3, 1'b0, 1'b0);
        finish_turn(1, 0, 3, 1'b0, 1'b0);

        illegal(3'b011);
        illegal(3'b000);
        illegal(3'b111);

        // Randomized turns; odd turns keep move_valid asserted with another code
        for (int i = 0; i < 8; i++) begin
            logic [MOVE_W-1:0] mv;
            int cols, dl;
            mv   = MOVE_W'(1 << $urandom_range(0, 2));
            cols = $urandom_range(1, 12);
            dl   = $urandom_range(1, 5);
            repeat ($urandom_range(0, 3)) tick();
            start_turn(mv, cols, dl, 1'b0, bit'(i % 2));
            finish_turn(cols, cols - 1, dl, 1'b0, 1'b0);
        end

        // Game over during CHECK: bar still stepped, then terminal
        start_turn(3'b100, 4, 2, 1'b1, 1'b0);
        finish_turn(4, 3, 2, 1'b1, 1'b0);
        clear_model();
        move_in = 3'b001; move_valid = 1'b1;
        repeat (10) tick();
        move_valid = 1'b0;
        check("over_no_accept", n_reg + n_done + steps, 0);
        check("over_ready", move_ready, 0);
        check("over_busy", busy, 0);
        check("over_sticky", battle_over, 1);
        do_reset();
        check("over_cleared_by_reset", battle_over, 0);

        // Reset in the middle of a DRAW burst with battle_over already set
        start_turn(3'b001, 5, 7, 1'b1, 1'b0);
        budget = 0;
        while (draw_run < 3 && budget < 100) begin
            tick();
            budget++;
        end
        check("reached_draw", draw_run, 3);
        check("bo_before_reset", battle_over, 1);
        in_turn = 1'b0; go_all = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_draw_reset_outputs", out_vec(), 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("ready_after_mid_reset", move_ready, 1);
        check("bo_after_mid_reset", battle_over, 0);
        clear_model();

        // Draw that never completes
`ifdef DMG_SEQ_TIMEOUT_EN
        start_turn(3'b010, 3, 0, 1'b0, 1'b0);
        finish_turn(1, 1, TIMEOUT, 1'b0, 1'b1);
        start_turn(3'b001, 2, 2, 1'b0, 1'b0);
        finish_turn(2, 1, 2, 1'b0, 1'b1);
`else
        start_turn(3'b010, 3, 0, 1'b0, 1'b0);
        repeat (60) tick();
        check("draw_persists", enable_draw_decrease, 1);
        check("draw_persist_len", draw_run, 55);
        check("no_turn_done_hang", n_done, 0);
        check("timeout_err_off", timeout_err, 0);
        do_reset();
        check("ready_after_hang_reset", move_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
